// File: rtl/subservient_sram_pkg.sv
// Shared types and address helpers for the subservient byte-port to wide-SRAM bridge.
package subservient_sram_pkg;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } buf_state_e;

  localparam int DEFAULT_MDW = 32;

  // Number of byte-lane address bits for a macro of width mdw.
  function automatic int lb_of(input int mdw);
    return $clog2(mdw / 8);
  endfunction

  localparam int LB = lb_of(DEFAULT_MDW);

  function automatic int unsigned lane_of(input int unsigned addr, input int lb);
    return addr & ((32'd1 << lb) - 32'd1);
  endfunction

  function automatic int unsigned word_of(input int unsigned addr, input int lb);
    return addr >> lb;
  endfunction

endpackage

// File: rtl/subservient_sram_rdpipe.sv
// Read-side delay line carrying forward data alongside the macro read,
// and the final select between forwarded byte and macro lane.
module subservient_sram_rdpipe
  import subservient_sram_pkg::*;
#(
  parameter int MDW    = 32,
  parameter int RD_LAT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fwd_hit,
  input  logic [7:0]                 i_fwd_byte,
  input  logic [$clog2(MDW/8)-1:0]   i_lane,
  input  logic [MDW-1:0]             i_m_rdata,
  output logic [7:0]                 o_rdata
);

  localparam int LANE_BITS = lb_of(MDW);

  typedef struct packed {
    logic                 vld;
    logic                 hit;
    logic [7:0]           byt;
    logic [LANE_BITS-1:0] lane;
  } stage_t;

  stage_t pipe_reg [RD_LAT];
  stage_t tail;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= '{vld: 1'b1, hit: i_fwd_hit, byt: i_fwd_byte, lane: i_lane};
      for (int i = 1; i < RD_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign tail = pipe_reg[RD_LAT-1];

  // Forwarded bytes override the macro, which may return stale data on a collision.
  always_comb begin
    o_rdata = 8'h00;
    if (tail.vld) o_rdata = tail.hit ? tail.byt : i_m_rdata[{tail.lane, 3'b000} +: 8];
  end

endmodule

// File: rtl/subservient_sram_bridge.sv
// Byte-wide 1W1R port to wide masked-write SRAM macro, with a one-word
// write-coalescing buffer and read-after-write forwarding.
module subservient_sram_bridge
  import subservient_sram_pkg::*;
#(
  parameter int AW           = 13,
  parameter int MDW          = 32,
  parameter int RD_LAT       = 1,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [AW-1:0]                 i_waddr,
  input  logic [7:0]                    i_wdata,
  input  logic                          i_wen,
  input  logic [AW-1:0]                 i_raddr,
  output logic [7:0]                    o_rdata,
  input  logic                          i_flush,
  output logic                          o_idle,
  output logic                          o_m_we,
  output logic [MDW/8-1:0]              o_m_wmask,
  output logic [AW-$clog2(MDW/8)-1:0]   o_m_waddr,
  output logic [MDW-1:0]                o_m_wdata,
  output logic                          o_m_re,
  output logic [AW-$clog2(MDW/8)-1:0]   o_m_raddr,
  input  logic [MDW-1:0]                i_m_rdata
);

  localparam int LANE_BITS = lb_of(MDW);
  localparam int NL        = MDW / 8;
  localparam int WW        = AW - LANE_BITS;
  localparam int CW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  buf_state_e           state_reg, state_next;
  logic [WW-1:0]        buf_word_reg, buf_word_next;
  logic [MDW-1:0]       buf_data_reg, buf_data_next;
  logic [NL-1:0]        buf_mask_reg, buf_mask_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 flush_pend_reg, flush_pend_next;
  logic                 m_we_reg, m_we_next;
  logic [NL-1:0]        m_wmask_reg, m_wmask_next;
  logic [WW-1:0]        m_waddr_reg, m_waddr_next;
  logic [MDW-1:0]       m_wdata_reg, m_wdata_next;

  logic [WW-1:0]        w_word, r_word;
  logic [LANE_BITS-1:0] w_lane, r_lane;
  logic [NL-1:0]        w_onehot;
  logic [MDW-1:0]       masked_data;
  logic                 flush_req, flush_due;
  logic                 fwd_hit;
  logic [7:0]           fwd_byte;

  assign w_word   = WW'(word_of(32'(i_waddr), LANE_BITS));
  assign w_lane   = LANE_BITS'(lane_of(32'(i_waddr), LANE_BITS));
  assign r_word   = WW'(word_of(32'(i_raddr), LANE_BITS));
  assign r_lane   = LANE_BITS'(lane_of(32'(i_raddr), LANE_BITS));
  assign w_onehot = NL'(1) << w_lane;

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_lane
      assign masked_data[gi*8 +: 8] = buf_mask_reg[gi] ? buf_data_reg[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // A flush that arrives with a write is held over until a write-free cycle.
  assign flush_req = i_flush || flush_pend_reg;
  assign flush_due = flush_req || ((FLUSH_CYCLES != 0) && (cnt_reg == CW'(FLUSH_CYCLES - 1)));

  always_comb begin
    state_next      = state_reg;
    buf_word_next   = buf_word_reg;
    buf_data_next   = buf_data_reg;
    buf_mask_next   = buf_mask_reg;
    cnt_next        = cnt_reg;
    flush_pend_next = flush_req && i_wen;
    m_we_next       = 1'b0;
    m_wmask_next    = '0;
    m_waddr_next    = m_waddr_reg;
    m_wdata_next    = '0;
    case (state_reg)
      EMPTY: begin
        if (i_wen) begin
          state_next                          = PENDING;
          buf_word_next                       = w_word;
          buf_mask_next                       = w_onehot;
          buf_data_next[{w_lane, 3'b000} +: 8] = i_wdata;
          cnt_next                            = '0;
        end
      end
      PENDING: begin
        if (i_wen) begin
          cnt_next                            = '0;
          buf_data_next[{w_lane, 3'b000} +: 8] = i_wdata;
          if (w_word != buf_word_reg) begin
            m_we_next     = 1'b1;
            m_wmask_next  = buf_mask_reg;
            m_waddr_next  = buf_word_reg;
            m_wdata_next  = masked_data;
            buf_word_next = w_word;
            buf_mask_next = w_onehot;
          end else begin
            buf_mask_next = buf_mask_reg | w_onehot;
          end
        end else if (flush_due) begin
          m_we_next     = 1'b1;
          m_wmask_next  = buf_mask_reg;
          m_waddr_next  = buf_word_reg;
          m_wdata_next  = masked_data;
          state_next    = EMPTY;
          buf_mask_next = '0;
          cnt_next      = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= EMPTY;
      buf_word_reg   <= '0;
      buf_data_reg   <= '0;
      buf_mask_reg   <= '0;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      m_we_reg       <= 1'b0;
      m_wmask_reg    <= '0;
      m_waddr_reg    <= '0;
      m_wdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      buf_word_reg   <= buf_word_next;
      buf_data_reg   <= buf_data_next;
      buf_mask_reg   <= buf_mask_next;
      cnt_reg        <= cnt_next;
      flush_pend_reg <= flush_pend_next;
      m_we_reg       <= m_we_next;
      m_wmask_reg    <= m_wmask_next;
      m_waddr_reg    <= m_waddr_next;
      m_wdata_reg    <= m_wdata_next;
    end
  end

  // Newest copy wins: same-cycle write, then buffer, then the write leaving this cycle.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_byte = 8'h00;
    if (i_wen && (i_waddr == i_raddr)) begin
      fwd_hit  = 1'b1;
      fwd_byte = i_wdata;
    end else if ((state_reg == PENDING) && (buf_word_reg == r_word) && buf_mask_reg[r_lane]) begin
      fwd_hit  = 1'b1;
      fwd_byte = buf_data_reg[{r_lane, 3'b000} +: 8];
    end else if (m_we_reg && (m_waddr_reg == r_word) && m_wmask_reg[r_lane]) begin
      fwd_hit  = 1'b1;
      fwd_byte = m_wdata_reg[{r_lane, 3'b000} +: 8];
    end
  end

  subservient_sram_rdpipe #(
    .MDW    (MDW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_fwd_hit  (fwd_hit),
    .i_fwd_byte (fwd_byte),
    .i_lane     (r_lane),
    .i_m_rdata  (i_m_rdata),
    .o_rdata    (o_rdata)
  );

  assign o_idle    = (state_reg == EMPTY) && !m_we_reg;
  assign o_m_we    = m_we_reg;
  assign o_m_wmask = m_wmask_reg;
  assign o_m_waddr = m_waddr_reg;
  assign o_m_wdata = m_wdata_reg;
  assign o_m_re    = !i_rst;
  assign o_m_raddr = r_word;

endmodule

// File: tb/tb_subservient_sram_bridge.sv
// Directed checks on a 32-bit/latency-1 bridge, then a random sweep of a
// 64-bit/latency-3 bridge against a flat byte-array memory model.
module tb_subservient_sram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: MDW=32, RD_LAT=1, FLUSH_CYCLES=8
  logic        a_rst, a_wen, a_flush, a_idle, a_we, a_re;
  logic [12:0] a_waddr, a_raddr;
  logic [7:0]  a_wdata, a_rdata;
  logic [3:0]  a_wmask;
  logic [10:0] a_m_waddr, a_m_raddr;
  logic [31:0] a_m_wdata, a_m_rdata;

  // Instance B: MDW=64, RD_LAT=3, FLUSH_CYCLES=8
  logic        b_rst, b_wen, b_flush, b_idle, b_we, b_re;
  logic [12:0] b_waddr, b_raddr;
  logic [7:0]  b_wdata, b_rdata;
  logic [7:0]  b_wmask;
  logic [9:0]  b_m_waddr, b_m_raddr;
  logic [63:0] b_m_wdata, b_m_rdata;

  subservient_sram_bridge #(.AW(13), .MDW(32), .RD_LAT(1), .FLUSH_CYCLES(8)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_waddr(a_waddr), .i_wdata(a_wdata), .i_wen(a_wen),
    .i_raddr(a_raddr), .o_rdata(a_rdata), .i_flush(a_flush), .o_idle(a_idle),
    .o_m_we(a_we), .o_m_wmask(a_wmask), .o_m_waddr(a_m_waddr), .o_m_wdata(a_m_wdata),
    .o_m_re(a_re), .o_m_raddr(a_m_raddr), .i_m_rdata(a_m_rdata)
  );

  subservient_sram_bridge #(.AW(13), .MDW(64), .RD_LAT(3), .FLUSH_CYCLES(8)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_waddr(b_waddr), .i_wdata(b_wdata), .i_wen(b_wen),
    .i_raddr(b_raddr), .o_rdata(b_rdata), .i_flush(b_flush), .o_idle(b_idle),
    .o_m_we(b_we), .o_m_wmask(b_wmask), .o_m_waddr(b_m_waddr), .o_m_wdata(b_m_wdata),
    .o_m_re(b_re), .o_m_raddr(b_m_raddr), .i_m_rdata(b_m_rdata)
  );

  // Macro for instance B: masked write port, read-first 3-cycle read port.
  logic [63:0] b_mem [1024];
  logic [63:0] b_rpipe [3];
  int          b_nwr;

  always @(posedge clk) begin
    if (b_rst) begin
      for (int i = 0; i < 1024; i++) b_mem[i] <= 64'h0;
      for (int i = 0; i < 3; i++) b_rpipe[i] <= 64'h0;
      b_nwr <= 0;
    end else begin
      b_rpipe[0] <= b_mem[b_m_raddr];
      b_rpipe[1] <= b_rpipe[0];
      b_rpipe[2] <= b_rpipe[1];
      if (b_we) begin
        b_nwr <= b_nwr + 1;
        for (int k = 0; k < 8; k++)
          if (b_wmask[k]) b_mem[b_m_waddr][k*8 +: 8] <= b_m_wdata[k*8 +: 8];
      end
    end
  end
  assign b_m_rdata = b_rpipe[2];

  logic [7:0] model [8192];
  logic [7:0] exp_q [$];
  int         nw = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_cycle(input logic wen, input logic [12:0] wa, input logic [7:0] wd,
                         input logic [12:0] ra, input logic fl);
    logic [7:0] e;
    b_wen = wen; b_waddr = wa; b_wdata = wd; b_raddr = ra; b_flush = fl;
    if (wen) begin
      model[wa] = wd;
      nw++;
    end
    exp_q.push_back(model[ra]);
    tick();
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk("b_rdata", 64'(b_rdata), 64'(e));
    end
  endtask

  initial begin
    logic [7:0] e;
    a_rst = 1'b1; a_wen = 1'b0; a_flush = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
    a_m_rdata = 32'h0;
    b_rst = 1'b1; b_wen = 1'b0; b_flush = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
    for (int i = 0; i < 8192; i++) model[i] = 8'h00;

    repeat (2) tick();
    chk("reset_we",    64'(a_we), 64'd0);
    chk("reset_wmask", 64'(a_wmask), 64'd0);
    chk("reset_idle",  64'(a_idle), 64'd1);
    chk("reset_rdata", 64'(a_rdata), 64'd0);
    chk("reset_re",    64'(a_re), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("re_high", 64'(a_re), 64'd1);
    chk("b_re_high", 64'(b_re), 64'd1);

    // Four coalesced byte writes, then timeout flush after 8 idle cycles.
    for (int i = 0; i < 4; i++) begin
      a_wen = 1'b1; a_waddr = 13'(i); a_wdata = 8'(8'h11 * (i + 1));
      tick();
    end
    a_wen = 1'b0;
    chk("pending_not_idle", 64'(a_idle), 64'd0);
    for (int j = 0; j < 8; j++) begin
      chk("no_early_we", 64'(a_we), 64'd0);
      tick();
    end
    chk("tmo_we",    64'(a_we), 64'd1);
    chk("tmo_waddr", 64'(a_m_waddr), 64'd0);
    chk("tmo_wmask", 64'(a_wmask), 64'hF);
    chk("tmo_wdata", 64'(a_m_wdata), 64'h44332211);
    tick();
    chk("tmo_single_pulse", 64'(a_we), 64'd0);
    chk("tmo_idle", 64'(a_idle), 64'd1);

    // Eviction on a write to a different word.
    a_wen = 1'b1; a_waddr = 13'd5; a_wdata = 8'hAA;
    tick();
    a_waddr = 13'd12; a_wdata = 8'hBB; a_raddr = 13'd12;
    tick();
    a_wen = 1'b0;
    chk("m_raddr", 64'(a_m_raddr), 64'd3);
    chk("evict_we",    64'(a_we), 64'd1);
    chk("evict_waddr", 64'(a_m_waddr), 64'd1);
    chk("evict_wmask", 64'(a_wmask), 64'b0010);
    chk("evict_wdata", 64'(a_m_wdata), 64'h0000AA00);
    a_flush = 1'b1; a_raddr = 13'd0;
    tick();
    a_flush = 1'b0;
    chk("flush_waddr", 64'(a_m_waddr), 64'd3);
    chk("flush_wmask", 64'(a_wmask), 64'b0001);
    chk("flush_wdata", 64'(a_m_wdata), 64'h000000BB);
    tick();
    chk("flush_idle", 64'(a_idle), 64'd1);

    // Forwarding: same-cycle write, buffer hit, in-flight write, then macro.
    a_m_rdata = 32'hDEADBEEF;
    a_wen = 1'b1; a_waddr = 13'd2; a_wdata = 8'h5A; a_raddr = 13'd2;
    tick();
    a_wen = 1'b0;
    chk("fwd_same_cycle", 64'(a_rdata), 64'h5A);
    tick();
    chk("fwd_buffer", 64'(a_rdata), 64'h5A);
    a_raddr = 13'd3;
    tick();
    chk("macro_lane3", 64'(a_rdata), 64'hDE);
    a_raddr = 13'd2; a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("fwd_buffer_flush", 64'(a_rdata), 64'h5A);
    tick();
    chk("fwd_inflight", 64'(a_rdata), 64'h5A);
    tick();
    chk("macro_after_flush", 64'(a_rdata), 64'hAD);
    a_m_rdata = 32'h0; a_raddr = 13'd0;

    // Flush coinciding with a write to a new word.
    a_wen = 1'b1; a_waddr = 13'h040; a_wdata = 8'h77;
    tick();
    a_waddr = 13'h080; a_wdata = 8'h99; a_flush = 1'b1;
    tick();
    a_wen = 1'b0; a_flush = 1'b0;
    chk("fw_old_we",    64'(a_we), 64'd1);
    chk("fw_old_waddr", 64'(a_m_waddr), 64'd16);
    chk("fw_old_wdata", 64'(a_m_wdata), 64'h77);
    chk("fw_busy", 64'(a_idle), 64'd0);
    tick();
    chk("fw_new_we",    64'(a_we), 64'd1);
    chk("fw_new_waddr", 64'(a_m_waddr), 64'd32);
    chk("fw_new_wmask", 64'(a_wmask), 64'b0001);
    chk("fw_new_wdata", 64'(a_m_wdata), 64'h99);
    tick();
    chk("fw_idle", 64'(a_idle), 64'd1);

    // Reset while a byte is pending discards it.
    a_wen = 1'b1; a_waddr = 13'd2; a_wdata = 8'h66;
    tick();
    a_wen = 1'b0;
    a_rst = 1'b1;
    #1;
    chk("rst_we",    64'(a_we), 64'd0);
    chk("rst_idle",  64'(a_idle), 64'd1);
    chk("rst_rdata", 64'(a_rdata), 64'd0);
    tick();
    a_rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("rst_no_we", 64'(a_we), 64'd0);
    end
    a_raddr = 13'd2;
    tick();
    chk("rst_discarded", 64'(a_rdata), 64'd0);

    // Random sweep on the wide, long-latency instance.
    for (int i = 0; i < 400; i++)
      b_cycle(1'($urandom_range(0, 1)), 13'($urandom_range(0, 63)), 8'($urandom),
              13'($urandom_range(0, 63)), 1'($urandom_range(0, 9) == 0));
    for (int i = 0; i < 64; i++)
      b_cycle(1'b0, 13'd0, 8'h00, 13'(i), 1'b0);
    b_wen = 1'b0; b_flush = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      b_flush = 1'b0;
      e = exp_q.pop_front();
      chk("b_rdata", 64'(b_rdata), 64'(e));
    end
    repeat (3) tick();
    chk("b_idle", 64'(b_idle), 64'd1);
    chk("b_wr_count", 64'((b_nwr <= nw) && (b_nwr > 0)), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
